motor_drive_pwm: RTL
====================

Name: motor_drive_pwm

Overview:
- Downstream stage of the line-follower direction controller.
- Consumes the registered 4-bit steering code DIR and the travel-direction flag, and produces per-motor PWM and H-bridge polarity.
- Applies slew-rate-limited duty ramps and a timed pivot sequence for 90-degree turns.
- Output pins go straight to the left/right H-bridge drivers.

Parameters:
- PWM_PERIOD, 1000: PWM period in clk cycles (50 kHz at 50 MHz); duty range 0..PWM_PERIOD.
- DUTY_W, 10: width of the duty and PWM counter registers; must hold PWM_PERIOD.
- DUTY_VEER, 600: inner-wheel duty for a veer.
- DUTY_HARD, 250: inner-wheel duty for a hard turn.
- RAMP_DIV, 5000: clk cycles between duty ramp steps.
- RAMP_STEP, 50: duty change per ramp step.
- PIVOT_CYCLES, 25_000_000: pivot hold time (500 ms).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = drive permitted; 0 = outputs off
- DIR  in  4  steering code: {turn[1:0], severity[1:0]}
- Direction  in  1  1 = forwards, 0 = backwards
- l_pwm  out  1  left motor PWM
- r_pwm  out  1  right motor PWM
- l_fwd  out  1  left H-bridge polarity; 1 = travel-forward rotation
- r_fwd  out  1  right H-bridge polarity
- busy  out  1  high while a pivot (PIVOT_RAMP or PIVOT) is in progress

Behaviour:
- Reset values:
  - l_pwm = r_pwm = 0, busy = 0.
  - l_fwd = r_fwd = 1.
  - Both duty registers = 0, both targets = 0, PWM and ramp counters = 0, FSM = IDLE.
- Input registering: DIR and Direction are registered once; a decode change reaches the targets 1 cycle after the input changes.
- Decode in RUN (outer wheel = PWM_PERIOD):
  - 0000 PROCEED: both PWM_PERIOD.
  - 0101 VEER_LEFT: left = DUTY_VEER. 0110 HARD_LEFT: left = DUTY_HARD.
  - 1001 VEER_RIGHT: right = DUTY_VEER. 1010 HARD_RIGHT: right = DUTY_HARD.
  - 1111 STOP: both 0.
  - 0111 / 1011: start a left / right pivot.
  - Any other code is treated as STOP.
- Polarity in RUN: l_fwd = r_fwd = Direction.
- Ramp:
  - Every RAMP_DIV cycles, each duty moves toward its target by min(RAMP_STEP, |target - duty|).
  - Arithmetic is saturating: duty never goes below 0 or above PWM_PERIOD.
  - STOP and enable=0 bypass the ramp: duty is forced to 0 on the next cycle.
- PWM generation:
  - A free-running counter runs 0..PWM_PERIOD-1 and wraps.
  - pwm = (cnt < duty), registered.
  - duty 0 gives a constant low; duty PWM_PERIOD gives a constant high.
  - A new duty takes effect only at counter wrap, so there are no runt pulses.
- Polarity flip rule: a motor's fwd bit may change only while that motor's duty == 0.
- FSM:
  - IDLE: outputs off. Goes to RUN when enable=1.
  - RUN: decode as above. A 90-degree code latches the pivot side, asserts busy, and goes to PIVOT_RAMP.
  - PIVOT_RAMP: both duties ramp to 0. When both are 0, set the inner wheel fwd = ~Direction and the outer wheel fwd = Direction, set both targets = PWM_PERIOD, clear the pivot timer, go to PIVOT.
  - PIVOT: DIR is ignored. The timer counts to PIVOT_CYCLES-1, then both duties ramp to 0, polarity is restored, busy drops, and the FSM returns to RUN.
  - HALT: entered on STOP in RUN. Duties stay 0. Any non-STOP code returns to RUN.
- Simultaneous / boundary events:
  - enable=0 in any state (including mid-pivot) goes to IDLE within 1 cycle, forces duty 0, clears busy and the pivot timer. Polarity is restored to Direction on the next cycle, since duty is then 0.
  - A STOP code during PIVOT is ignored.
  - A Direction change in RUN ramps the affected duties to 0, flips polarity, then ramps back up to target.
  - rst_n assertion at any time gives the reset values immediately.

Decomposition:
- Shared package, used by the direction controller and this block:
  - steering code constants: PROCEED, VEER_*, HARD_*, NINETY_*, STOP;
  - FSM state enum;
  - default duty levels.
- One sub-module, pwm_channel: PWM counter comparator plus saturating ramp for one motor. Instantiated twice; the pivot timer is shared in the top.

Test Plan:
Bench parameters: PWM_PERIOD=10, RAMP_DIV=2, RAMP_STEP=5, PIVOT_CYCLES=40.
- Reset: hold rst_n=0 mid-run -> l_pwm=r_pwm=0, l_fwd=r_fwd=1, busy=0 in the same cycle; after release, stays off until enable=1.
- Ramp: enable=1, DIR=0000, Direction=1 -> duty 0 → 5 → 10 in two ramp steps; after that, both PWMs constantly high.
- Veer: DIR=0101 in RUN -> left duty settles at DUTY_VEER (10-cycle window shows that many high cycles); right stays 10.
- Pivot: DIR=1011 -> busy=1; both duties reach 0 before r_fwd goes to 0; right runs reversed at duty 10 for 40 cycles while DIR toggles are ignored; then duties ramp to 0, r_fwd returns to 1, busy=0.
- Safety: DIR=1111 -> duty 0 next cycle with no ramp. Illegal code 0100 -> same response. enable=0 mid-pivot -> IDLE, busy=0 within 1 cycle.
- Reversal: Direction 1→0 while at full duty -> the fwd bits never change while duty ≠ 0; both wheels ramp back to 10 with fwd=0.

Source files
------------

// File: rtl/motor_drive_pwm_pkg.sv
// Shared definitions for the line-follower drive path: steering codes,
// drive FSM state encodings and default duty/timing levels.
package motor_drive_pwm_pkg;

  // Steering codes {turn[1:0], severity[1:0]}
  localparam logic [3:0] CODE_PROCEED      = 4'b0000;
  localparam logic [3:0] CODE_VEER_LEFT    = 4'b0101;
  localparam logic [3:0] CODE_HARD_LEFT    = 4'b0110;
  localparam logic [3:0] CODE_NINETY_LEFT  = 4'b0111;
  localparam logic [3:0] CODE_VEER_RIGHT   = 4'b1001;
  localparam logic [3:0] CODE_HARD_RIGHT   = 4'b1010;
  localparam logic [3:0] CODE_NINETY_RIGHT = 4'b1011;
  localparam logic [3:0] CODE_STOP         = 4'b1111;

  // Drive FSM states
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RUN        = 3'd1;
  localparam logic [2:0] ST_PIVOT_RAMP = 3'd2;
  localparam logic [2:0] ST_PIVOT      = 3'd3;
  localparam logic [2:0] ST_HALT       = 3'd4;

  // Default levels (50 MHz clock)
  localparam int DEF_PWM_PERIOD   = 1000;
  localparam int DEF_DUTY_W       = 10;
  localparam int DEF_DUTY_VEER    = 600;
  localparam int DEF_DUTY_HARD    = 250;
  localparam int DEF_RAMP_DIV     = 5000;
  localparam int DEF_RAMP_STEP    = 50;
  localparam int DEF_PIVOT_CYCLES = 25_000_000;

  // True for codes that drive both wheels forward-ish (no stop, no pivot)
  function automatic logic is_drive_code(input logic [3:0] code);
    logic hit;
    case (code)
      CODE_PROCEED, CODE_VEER_LEFT, CODE_HARD_LEFT,
      CODE_VEER_RIGHT, CODE_HARD_RIGHT: hit = 1'b1;
      default:                          hit = 1'b0;
    endcase
    return hit;
  endfunction

  // True for the two 90-degree pivot codes
  function automatic logic is_pivot_code(input logic [3:0] code);
    return (code == CODE_NINETY_LEFT) || (code == CODE_NINETY_RIGHT);
  endfunction

endpackage

// File: rtl/motor_drive_pwm_pwm_channel.sv
// One motor channel: saturating duty ramp toward a target, free-running PWM
// counter, and a comparator whose duty is only reloaded at counter wrap.
module pwm_channel
  import motor_drive_pwm_pkg::*;
#(
  parameter int PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int DUTY_W     = DEF_DUTY_W,
  parameter int RAMP_STEP  = DEF_RAMP_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              force_off,
  input  logic [DUTY_W-1:0] target,
  output logic              pwm,
  output logic              off
);

  localparam logic [DUTY_W-1:0] PERIOD_C = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] LAST_C   = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] STEP_C   = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] ONE_C    = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] ZERO_C   = {DUTY_W{1'b0}};

  logic [DUTY_W-1:0] cnt_r;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] act_r;
  logic              pwm_r;
  logic [DUTY_W-1:0] tgt_sat_s;
  logic [DUTY_W-1:0] gap_s;
  logic [DUTY_W-1:0] duty_nxt_s;
  logic              wrap_s;

  assign wrap_s = (cnt_r == LAST_C);

  // Next ramp value: move toward the clamped target by at most one step
  always_comb begin
    tgt_sat_s  = (target > PERIOD_C) ? PERIOD_C : target;
    gap_s      = ZERO_C;
    duty_nxt_s = duty_r;
    if (tgt_sat_s > duty_r) begin
      gap_s      = tgt_sat_s - duty_r;
      duty_nxt_s = duty_r + ((gap_s < STEP_C) ? gap_s : STEP_C);
    end else begin
      gap_s      = duty_r - tgt_sat_s;
      duty_nxt_s = duty_r - ((gap_s < STEP_C) ? gap_s : STEP_C);
    end
  end

  // Free-running PWM period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= ZERO_C;
    end else if (wrap_s) begin
      cnt_r <= ZERO_C;
    end else begin
      cnt_r <= cnt_r + ONE_C;
    end
  end

  // Duty ramp register; forced off bypasses the ramp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r <= ZERO_C;
    end else if (force_off) begin
      duty_r <= ZERO_C;
    end else if (tick) begin
      duty_r <= duty_nxt_s;
    end else begin
      duty_r <= duty_r;
    end
  end

  // Comparator: active duty reloads at wrap so no runt pulses; force_off is immediate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_r <= ZERO_C;
      pwm_r <= 1'b0;
    end else if (force_off) begin
      act_r <= ZERO_C;
      pwm_r <= 1'b0;
    end else begin
      if (wrap_s) begin
        act_r <= duty_r;
      end else begin
        act_r <= act_r;
      end
      pwm_r <= (cnt_r < act_r);
    end
  end

  assign pwm = pwm_r;
  // Fully de-energised: safe point for an H-bridge polarity change
  assign off = (duty_r == ZERO_C) && (act_r == ZERO_C) && !pwm_r;

endmodule

// File: rtl/motor_drive_pwm.sv
// Motor drive stage: decodes the registered steering code into per-wheel duty
// targets, sequences 90-degree pivots, and only flips H-bridge polarity while a
// wheel is fully de-energised.
module motor_drive_pwm
  import motor_drive_pwm_pkg::*;
#(
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int DUTY_W       = DEF_DUTY_W,
  parameter int DUTY_VEER    = DEF_DUTY_VEER,
  parameter int DUTY_HARD    = DEF_DUTY_HARD,
  parameter int RAMP_DIV     = DEF_RAMP_DIV,
  parameter int RAMP_STEP    = DEF_RAMP_STEP,
  parameter int PIVOT_CYCLES = DEF_PIVOT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] DIR,
  input  logic       Direction,
  output logic       l_pwm,
  output logic       r_pwm,
  output logic       l_fwd,
  output logic       r_fwd,
  output logic       busy
);

  localparam int PIV_W = $clog2(PIVOT_CYCLES + 1);
  localparam int DIV_W = $clog2(RAMP_DIV + 1);
  localparam logic [DUTY_W-1:0] FULL_C     = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] VEER_C     = DUTY_W'(DUTY_VEER);
  localparam logic [DUTY_W-1:0] HARD_C     = DUTY_W'(DUTY_HARD);
  localparam logic [DUTY_W-1:0] ZERO_C     = {DUTY_W{1'b0}};
  localparam logic [PIV_W-1:0]  PIV_LAST_C = PIV_W'(PIVOT_CYCLES - 1);
  localparam logic [PIV_W-1:0]  PIV_ONE_C  = PIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST_C = DIV_W'(RAMP_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE_C  = DIV_W'(1);

  logic [3:0]        dir_r;
  logic              direction_r;
  logic [2:0]        state_r;
  logic              pivot_left_r;
  logic              busy_r;
  logic [PIV_W-1:0]  pivot_cnt_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              l_fwd_r;
  logic              r_fwd_r;

  logic [2:0]        state_nxt_s;
  logic              pivot_left_nxt_s;
  logic [DUTY_W-1:0] l_base_s;
  logic [DUTY_W-1:0] r_base_s;
  logic [DUTY_W-1:0] l_tgt_s;
  logic [DUTY_W-1:0] r_tgt_s;
  logic              l_want_s;
  logic              r_want_s;
  logic              force_s;
  logic              tick_s;
  logic              pivot_done_s;
  logic              l_off_s;
  logic              r_off_s;

  assign tick_s       = (div_cnt_r == DIV_LAST_C);
  assign pivot_done_s = (pivot_cnt_r == PIV_LAST_C);

  // Decode and FSM next-state: base duty, desired polarity and forced-off per state
  always_comb begin
    state_nxt_s      = state_r;
    pivot_left_nxt_s = pivot_left_r;
    l_base_s         = ZERO_C;
    r_base_s         = ZERO_C;
    l_want_s         = direction_r;
    r_want_s         = direction_r;
    force_s          = 1'b0;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
      force_s     = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          force_s     = 1'b1;
          state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          case (dir_r)
            CODE_PROCEED:    begin l_base_s = FULL_C; r_base_s = FULL_C; end
            CODE_VEER_LEFT:  begin l_base_s = VEER_C; r_base_s = FULL_C; end
            CODE_HARD_LEFT:  begin l_base_s = HARD_C; r_base_s = FULL_C; end
            CODE_VEER_RIGHT: begin l_base_s = FULL_C; r_base_s = VEER_C; end
            CODE_HARD_RIGHT: begin l_base_s = FULL_C; r_base_s = HARD_C; end
            CODE_NINETY_LEFT: begin
              pivot_left_nxt_s = 1'b1;
              state_nxt_s      = ST_PIVOT_RAMP;
            end
            CODE_NINETY_RIGHT: begin
              pivot_left_nxt_s = 1'b0;
              state_nxt_s      = ST_PIVOT_RAMP;
            end
            default: begin
              force_s     = 1'b1;
              state_nxt_s = ST_HALT;
            end
          endcase
        end
        ST_PIVOT_RAMP: begin
          if (l_off_s && r_off_s) begin
            state_nxt_s = ST_PIVOT;
          end else begin
            state_nxt_s = ST_PIVOT_RAMP;
          end
        end
        ST_PIVOT: begin
          if (pivot_left_r) begin
            l_want_s = ~direction_r;
          end else begin
            r_want_s = ~direction_r;
          end
          if (!pivot_done_s) begin
            l_base_s = FULL_C;
            r_base_s = FULL_C;
          end else if (l_off_s && r_off_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PIVOT;
          end
        end
        ST_HALT: begin
          force_s = 1'b1;
          if (is_drive_code(dir_r) || is_pivot_code(dir_r)) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        default: begin
          force_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // A wheel whose polarity is still wrong ramps to zero first, then follows its base duty
  always_comb begin
    l_tgt_s = (l_fwd_r == l_want_s) ? l_base_s : ZERO_C;
    r_tgt_s = (r_fwd_r == r_want_s) ? r_base_s : ZERO_C;
  end

  // Capture steering code and travel direction once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r       <= CODE_PROCEED;
      direction_r <= 1'b1;
    end else begin
      dir_r       <= DIR;
      direction_r <= Direction;
    end
  end

  // FSM state, latched pivot side and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pivot_left_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pivot_left_r <= pivot_left_nxt_s;
      busy_r       <= (state_nxt_s == ST_PIVOT_RAMP) || (state_nxt_s == ST_PIVOT);
    end
  end

  // Pivot hold timer: counts while pivoting, cleared everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pivot_cnt_r <= {PIV_W{1'b0}};
    end else if ((state_r == ST_PIVOT) && enable) begin
      if (!pivot_done_s) begin
        pivot_cnt_r <= pivot_cnt_r + PIV_ONE_C;
      end else begin
        pivot_cnt_r <= pivot_cnt_r;
      end
    end else begin
      pivot_cnt_r <= {PIV_W{1'b0}};
    end
  end

  // Ramp step divider shared by both wheels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE_C;
    end
  end

  // H-bridge polarity follows the desired value only while that wheel is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_fwd_r <= 1'b1;
      r_fwd_r <= 1'b1;
    end else begin
      l_fwd_r <= l_off_s ? l_want_s : l_fwd_r;
      r_fwd_r <= r_off_s ? r_want_s : r_fwd_r;
    end
  end

  pwm_channel #(
    .PWM_PERIOD(PWM_PERIOD),
    .DUTY_W    (DUTY_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick_s),
    .force_off(force_s),
    .target   (l_tgt_s),
    .pwm      (l_pwm),
    .off      (l_off_s)
  );

  pwm_channel #(
    .PWM_PERIOD(PWM_PERIOD),
    .DUTY_W    (DUTY_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick_s),
    .force_off(force_s),
    .target   (r_tgt_s),
    .pwm      (r_pwm),
    .off      (r_off_s)
  );

  assign l_fwd = l_fwd_r;
  assign r_fwd = r_fwd_r;
  assign busy  = busy_r;

endmodule
